// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with busy scoreboard.
package regfile_pkg;

  localparam int RF_DATA_W = 64;
  localparam int RF_ADDR_W = 5;
  localparam int XZR       = 31;

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_bypass.sv
// One read port: zero-register decode, writeback bypass (B over A), array fallback,
// and busy masking when a matching write lands this cycle.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = XZR
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_busy,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  output logic [DATA_W-1:0] rd,
  output logic              rd_busy
);

  logic hit_a;
  logic hit_b;

  always_comb begin
    hit_a   = we_a && (wa_a == ra);
    hit_b   = we_b && (wa_b == ra);
    rd      = arr_data;
    rd_busy = arr_busy & ~(hit_a | hit_b);
    if (ra == ADDR_W'(ZERO_REG)) begin
      rd      = '0;
      rd_busy = 1'b0;
    end else if (hit_b) begin
      rd = wd_b;
    end else if (hit_a) begin
      rd = wd_a;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with per-register busy scoreboard
// and a hardwired zero register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = XZR,
  parameter int INIT_IDX = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_dst,
  input  logic                  we_a,
  input  logic [ADDR_W-1:0]     wa_a,
  input  logic [DATA_W-1:0]     wd_a,
  input  logic                  we_b,
  input  logic [ADDR_W-1:0]     wa_b,
  input  logic [DATA_W-1:0]     wd_b,
  output logic                  any_busy
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  // Port B is written after port A so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= (INIT_IDX != 0 && i != ZERO_REG) ? DATA_W'(i) : '0;
      end
    end else begin
      if (we_a && wa_a != ADDR_W'(ZERO_REG)) regs[wa_a] <= wd_a;
      if (we_b && wa_b != ADDR_W'(ZERO_REG)) regs[wa_b] <= wd_b;
    end
  end

  // A new issue supersedes a completing write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (r == ZERO_REG) begin
          busy[r] <= 1'b0;
        end else if (iss_valid && iss_dst == ADDR_W'(r)) begin
          busy[r] <= 1'b1;
        end else if ((we_a && wa_a == ADDR_W'(r)) || (we_b && wa_b == ADDR_W'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  assign any_busy = |busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra_p;
    assign ra_p = ra[p*ADDR_W +: ADDR_W];

    regfile_bypass #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .ra       (ra_p),
      .arr_data (regs[ra_p]),
      .arr_busy (busy[ra_p]),
      .we_a     (we_a),
      .wa_a     (wa_a),
      .wd_a     (wd_a),
      .we_b     (we_b),
      .wa_b     (wa_b),
      .wd_b     (wd_b),
      .rd       (rd[p*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (64-bit, 32 regs, 2 read ports, XZR=31).
module tb_regfile_sb;
  import regfile_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [9:0]     ra;
  logic [127:0]   rd;
  logic [1:0]     rd_busy;
  logic           iss_valid;
  reg_idx_t       iss_dst;
  logic           we_a;
  reg_idx_t       wa_a;
  reg_data_t      wd_a;
  logic           we_b;
  reg_idx_t       wa_b;
  reg_data_t      wd_b;
  logic           any_busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(
    .DATA_W   (64),
    .ADDR_W   (5),
    .NRD      (2),
    .ZERO_REG (31),
    .INIT_IDX (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .we_a      (we_a),
    .wa_a      (wa_a),
    .wd_a      (wd_a),
    .we_b      (we_b),
    .wa_b      (wa_b),
    .wd_b      (wd_b),
    .any_busy  (any_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_dst = '0;
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    ra = {5'd31, 5'd5};
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (rd[63:0] !== 64'd5) begin n_fail++; $display("FAIL reset_rd0: got %h expected %h", rd[63:0], 64'd5); end
    n_checks++; if (rd[127:64] !== 64'd0) begin n_fail++; $display("FAIL reset_rd1_xzr: got %h expected %h", rd[127:64], 64'd0); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy: got %b expected %b", rd_busy, 2'b00); end
    n_checks++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL reset_any_busy: got %b expected %b", any_busy, 1'b0); end
  endtask

  task automatic test_write_a();
    ra = {5'd3, 5'd3};
    #1;
    n_checks++; if (rd[63:0] !== 64'd3) begin n_fail++; $display("FAIL wa_pre: got %h expected %h", rd[63:0], 64'd3); end
    we_a = 1'b1; wa_a = 5'd3; wd_a = 64'hDEAD;
    #1;
    n_checks++; if (rd[63:0] !== 64'hDEAD) begin n_fail++; $display("FAIL wa_bypass0: got %h expected %h", rd[63:0], 64'hDEAD); end
    n_checks++; if (rd[127:64] !== 64'hDEAD) begin n_fail++; $display("FAIL wa_bypass1: got %h expected %h", rd[127:64], 64'hDEAD); end
    tick();
    idle();
    #1;
    n_checks++; if (rd[63:0] !== 64'hDEAD) begin n_fail++; $display("FAIL wa_stored: got %h expected %h", rd[63:0], 64'hDEAD); end
  endtask

  task automatic test_dual_write();
    ra = {5'd6, 5'd7};
    we_a = 1'b1; wa_a = 5'd7; wd_a = 64'h11;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 64'h22;
    #1;
    n_checks++; if (rd[63:0] !== 64'h22) begin n_fail++; $display("FAIL dual_bypass: got %h expected %h", rd[63:0], 64'h22); end
    n_checks++; if (rd[127:64] !== 64'd6) begin n_fail++; $display("FAIL dual_other_port: got %h expected %h", rd[127:64], 64'd6); end
    tick();
    idle();
    #1;
    n_checks++; if (rd[63:0] !== 64'h22) begin n_fail++; $display("FAIL dual_stored: got %h expected %h", rd[63:0], 64'h22); end
    // Port A alone bypasses when B targets another register.
    we_a = 1'b1; wa_a = 5'd6; wd_a = 64'h66;
    we_b = 1'b1; wa_b = 5'd8; wd_b = 64'h88;
    #1;
    n_checks++; if (rd[127:64] !== 64'h66) begin n_fail++; $display("FAIL a_bypass_b_other: got %h expected %h", rd[127:64], 64'h66); end
    tick();
    idle();
    ra = {5'd8, 5'd6};
    #1;
    n_checks++; if (rd[63:0] !== 64'h66) begin n_fail++; $display("FAIL a_stored6: got %h expected %h", rd[63:0], 64'h66); end
    n_checks++; if (rd[127:64] !== 64'h88) begin n_fail++; $display("FAIL b_stored8: got %h expected %h", rd[127:64], 64'h88); end
  endtask

  task automatic test_scoreboard();
    ra = {5'd10, 5'd9};
    iss_valid = 1'b1; iss_dst = 5'd9;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_pre_busy: got %b expected %b", rd_busy[0], 1'b0); end
    tick();
    idle();
    #1;
    n_checks++; if (rd_busy !== 2'b01) begin n_fail++; $display("FAIL sb_busy: got %b expected %b", rd_busy, 2'b01); end
    n_checks++; if (any_busy !== 1'b1) begin n_fail++; $display("FAIL sb_any_busy: got %b expected %b", any_busy, 1'b1); end
    n_checks++; if (rd[63:0] !== 64'd9) begin n_fail++; $display("FAIL sb_old_data: got %h expected %h", rd[63:0], 64'd9); end
    we_b = 1'b1; wa_b = 5'd9; wd_b = 64'h99;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_bypass_ready: got %b expected %b", rd_busy[0], 1'b0); end
    n_checks++; if (rd[63:0] !== 64'h99) begin n_fail++; $display("FAIL sb_bypass_data: got %h expected %h", rd[63:0], 64'h99); end
    n_checks++; if (any_busy !== 1'b1) begin n_fail++; $display("FAIL sb_any_busy_registered: got %b expected %b", any_busy, 1'b1); end
    tick();
    idle();
    #1;
    n_checks++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b expected %b", any_busy, 1'b0); end
    n_checks++; if (rd[63:0] !== 64'h99) begin n_fail++; $display("FAIL sb_stored: got %h expected %h", rd[63:0], 64'h99); end
  endtask

  task automatic test_issue_write_same();
    ra = {5'd9, 5'd4};
    iss_valid = 1'b1; iss_dst = 5'd4;
    tick();
    iss_valid = 1'b1; iss_dst = 5'd4;
    we_a = 1'b1; wa_a = 5'd4; wd_a = 64'h44;
    tick();
    idle();
    #1;
    n_checks++; if (rd[63:0] !== 64'h44) begin n_fail++; $display("FAIL iw_data: got %h expected %h", rd[63:0], 64'h44); end
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL iw_still_busy: got %b expected %b", rd_busy[0], 1'b1); end
    n_checks++; if (any_busy !== 1'b1) begin n_fail++; $display("FAIL iw_any_busy: got %b expected %b", any_busy, 1'b1); end
    we_a = 1'b1; wa_a = 5'd4; wd_a = 64'h45;
    tick();
    idle();
    #1;
    n_checks++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL iw_drained: got %b expected %b", any_busy, 1'b0); end
  endtask

  task automatic test_zero_reg();
    ra = {5'd31, 5'd31};
    we_a = 1'b1; wa_a = 5'd31; wd_a = 64'hFF;
    we_b = 1'b1; wa_b = 5'd31; wd_b = 64'hFF;
    iss_valid = 1'b1; iss_dst = 5'd31;
    #1;
    n_checks++; if (rd !== 128'd0) begin n_fail++; $display("FAIL xzr_bypass: got %h expected %h", rd, 128'd0); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL xzr_busy_now: got %b expected %b", rd_busy, 2'b00); end
    tick();
    idle();
    #1;
    n_checks++; if (rd !== 128'd0) begin n_fail++; $display("FAIL xzr_stored: got %h expected %h", rd, 128'd0); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL xzr_busy_after: got %b expected %b", rd_busy, 2'b00); end
    n_checks++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL xzr_any_busy: got %b expected %b", any_busy, 1'b0); end
  endtask

  task automatic test_reset_override();
    iss_valid = 1'b1; iss_dst = 5'd2;
    tick();
    idle();
    #1;
    n_checks++; if (any_busy !== 1'b1) begin n_fail++; $display("FAIL ro_pre_busy: got %b expected %b", any_busy, 1'b1); end
    reset = 1'b1;
    we_a = 1'b1; wa_a = 5'd2; wd_a = 64'hBEEF;
    iss_valid = 1'b1; iss_dst = 5'd2;
    tick();
    reset = 1'b0;
    idle();
    ra = {5'd3, 5'd2};
    #1;
    n_checks++; if (rd[63:0] !== 64'd2) begin n_fail++; $display("FAIL ro_reg2: got %h expected %h", rd[63:0], 64'd2); end
    n_checks++; if (rd[127:64] !== 64'd3) begin n_fail++; $display("FAIL ro_reg3_restored: got %h expected %h", rd[127:64], 64'd3); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL ro_rd_busy: got %b expected %b", rd_busy, 2'b00); end
    n_checks++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL ro_any_busy: got %b expected %b", any_busy, 1'b0); end
  endtask

  initial begin
    reset = 1'b1;
    ra = '0;
    idle();
    #2;
    test_reset();
    test_write_a();
    test_dual_write();
    test_scoreboard();
    test_issue_write_same();
    test_zero_reg();
    test_reset_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
